// File: rtl/instruction_loader.sv
// Instruction memory loader: byte stream -> big-endian words written at sequential addresses.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | accept word-count high byte
// LEN_LO  | accept word-count low byte, range check
// DATA    | accept data bytes of the current word
// WRITE   | one-cycle write strobe for the assembled word
// CHECK   | accept checksum byte (checksum build only)
// DONE    | load finished, done held until next start
module instruction_loader #(
   parameter int size   = 32,
   parameter int length = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       byteValid,
   input  logic [7:0]                 byteData,
   output logic                       byteReady,
   output logic                       wrEnable,
   output logic [$clog2(length)-1:0]  wrAddress,
   output logic [size-1:0]            wrData,
   output logic                       loading,
   output logic                       done,
   output logic                       error,
   output logic                       cpuStall
);

   localparam int          BPW   = size / 8;
   localparam int          AW    = $clog2(length);
   localparam int          BCW   = $clog2(BPW + 1);
   localparam logic [31:0] LEN32 = 32'(length);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [size-1:0]   word_q, word_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic [AW:0]       idx_q, idx_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [size-1:0]   data_q, data_d;
   logic              error_q, error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif
   logic              xfer;
   logic [15:0]       n_word;
   logic [size-1:0]   word_shift;

   assign byteReady  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
   assign xfer       = byteValid & byteReady;
   assign n_word     = {len_q[15:8], byteData};
   assign word_shift = size'({word_q, byteData});

   assign wrEnable  = (state_q == S_WRITE);
   assign wrAddress = addr_q;
   assign wrData    = data_q;
   assign done      = (state_q == S_DONE);
   assign error     = error_q;
   assign loading   = byteReady || (state_q == S_WRITE);
   assign cpuStall  = ~(done & ~error_q);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      word_d  = word_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      error_d = error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LEN_HI;
               error_d = 1'b0;
               idx_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = byteData;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d  = n_word;
               bcnt_d = BCW'(BPW - 1);
               if (n_word == 16'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_DONE;
`endif
               end else if (32'(n_word) > LEN32) begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d = word_shift;
`ifdef INSTR_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byteData;
`endif
               // down-counter reaches zero on the last byte of the word
               if (bcnt_q == '0) begin
                  data_d  = word_shift;
                  addr_d  = idx_q[AW-1:0];
                  bcnt_d  = BCW'(BPW - 1);
                  state_d = S_WRITE;
               end else begin
                  bcnt_d = bcnt_q - 1'b1;
               end
            end
         end
         S_WRITE: begin
            idx_d = idx_q + 1'b1;
            if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
         S_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (xfer) begin
               error_d = (byteData != csum_q);
               state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         word_q  <= '0;
         bcnt_q  <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         error_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         word_q  <= word_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         error_q <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes queued by stimulus, popped by a monitor.
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst_n, start, byteValid;
   logic [7:0]  byteData;
   logic        byteReady, wrEnable, loading, done, error, cpuStall;
   logic [7:0]  wrAddress;
   logic [31:0] wrData;

   instruction_loader #(.size(32), .length(256)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byteValid(byteValid), .byteData(byteData),
      .byteReady(byteReady), .wrEnable(wrEnable), .wrAddress(wrAddress), .wrData(wrData),
      .loading(loading), .done(done), .error(error), .cpuStall(cpuStall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] stim[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       prev_we = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
   endtask

   always @(negedge clk) begin
      if (rst_n && wrEnable) begin
         chk("wr_pulse_single_cycle", {63'd0, prev_we}, 64'd0);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", wrAddress, wrData);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_address", {56'd0, wrAddress}, {56'd0, w.a});
            chk("wr_data", {32'd0, wrData}, {32'd0, w.d});
         end
      end
      prev_we <= rst_n & wrEnable;
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_stream(input bit toggle, input int start_at);
      for (int i = 0; i < stim.size(); i++) begin
         int t;
         @(negedge clk);
         byteValid = 1'b1;
         byteData  = stim[i];
         if (i == start_at) start = 1'b1;
         t = 0;
         while (!byteReady && t < 200) begin
            @(negedge clk);
            start = 1'b0;
            t++;
         end
         if (t >= 200) begin
            chk("byte_accept_timeout", 64'(t), 64'd0);
            byteValid = 1'b0;
            start     = 1'b0;
            stim.delete();
            return;
         end
         @(posedge clk);
         #1;
         start     = 1'b0;
         byteValid = 1'b0;
         if (toggle) @(posedge clk);
      end
      stim.delete();
   endtask

   task automatic wait_done(input logic exp_err);
      int t;
      t = 0;
      @(negedge clk);
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("done", {63'd0, done}, 64'd1);
      chk("error", {63'd0, error}, {63'd0, exp_err});
      chk("cpu_stall", {63'd0, cpuStall}, {63'd0, exp_err});
      chk("writes_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cpu_stall"}, {63'd0, cpuStall}, 64'd1);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_error"}, {63'd0, error}, 64'd0);
      chk({tag, "_byte_ready"}, {63'd0, byteReady}, 64'd0);
      chk({tag, "_wr_enable"}, {63'd0, wrEnable}, 64'd0);
      chk({tag, "_loading"}, {63'd0, loading}, 64'd0);
      chk({tag, "_wr_address"}, {56'd0, wrAddress}, 64'd0);
      chk({tag, "_wr_data"}, {32'd0, wrData}, 64'd0);
   endtask

   task automatic two_word_stream();
      stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef INSTR_LOADER_CHECKSUM_EN
      stim.push_back(8'hAC);
`endif
      exp_wr(8'd0, 32'h20080005);
      exp_wr(8'd1, 32'h8C090004);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      byteValid = 1'b0;
      byteData  = 8'h00;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // basic two-word load
      pulse_start();
      chk("loading_after_start", {63'd0, loading}, 64'd1);
      chk("ready_in_len_hi", {63'd0, byteReady}, 64'd1);
      two_word_stream();
      send_stream(1'b0, -1);
      wait_done(1'b0);
      chk("loading_in_done", {63'd0, loading}, 64'd0);

      // N = 257 exceeds length: no writes, address/data hold last values
      pulse_start();
      chk("start_clears_done", {63'd0, done}, 64'd0);
      stim = '{8'h01, 8'h01};
      send_stream(1'b0, -1);
      wait_done(1'b1);
      chk("hold_wr_address", {56'd0, wrAddress}, 64'd1);
      chk("hold_wr_data", {32'd0, wrData}, 64'h8C090004);

      // gapped stream with start pulsed mid-load
      pulse_start();
      chk("start_clears_error", {63'd0, error}, 64'd0);
      two_word_stream();
      send_stream(1'b1, 5);
      wait_done(1'b0);

      // N = 0
      pulse_start();
      stim = '{8'h00, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
      stim.push_back(8'h00);
`endif
      send_stream(1'b0, -1);
      wait_done(1'b0);

      // N = length: last address 255, checksum of each word is 0
      pulse_start();
      stim = '{8'h01, 8'h00};
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = 8'(i);
         stim.push_back(b);
         stim.push_back(~b);
         stim.push_back(8'hA5);
         stim.push_back(8'h5A);
         exp_wr(b, {b, ~b, 8'hA5, 8'h5A});
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      stim.push_back(8'h00);
`endif
      send_stream(1'b0, -1);
      wait_done(1'b0);
      chk("full_last_address", {56'd0, wrAddress}, 64'd255);

      // reset after 5 data bytes, then a fresh load
      pulse_start();
      stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C};
      exp_wr(8'd0, 32'h20080005);
      send_stream(1'b0, -1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midload_reset");
      chk("midload_writes_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef INSTR_LOADER_CHECKSUM_EN
      stim.push_back(8'h22);
`endif
      exp_wr(8'd0, 32'hDEADBEEF);
      send_stream(1'b0, -1);
      wait_done(1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
      pulse_start();
      stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      exp_wr(8'd0, 32'h11223344);
      send_stream(1'b0, -1);
      wait_done(1'b0);

      pulse_start();
      stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      exp_wr(8'd0, 32'h11223344);
      send_stream(1'b0, -1);
      wait_done(1'b1);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
